// File: rtl/pll_reset_supervisor_if.sv
// Status and control signals exchanged between the PLL reset supervisor
// and its surroundings: PLL lock in, PLL/system resets and status out.
interface pll_reset_supervisor_if;
  logic       pll_locked;
  logic       sw_reset_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [7:0] lock_loss_count;
  logic [1:0] retry_count;

  modport master (
    output pll_locked, sw_reset_req,
    input  pll_rst, sys_rst, ready, fail, lock_loss_count, retry_count
  );

  modport slave (
    input  pll_locked, sw_reset_req,
    output pll_rst, sys_rst, ready, fail, lock_loss_count, retry_count
  );
endinterface

// File: rtl/pll_reset_supervisor.sv
// Sequences the PLL reset, qualifies lock, releases the system reset and
// recovers from lock loss; all outputs are registered decodes of the state.
module pll_reset_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE   = 64,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned RELEASE_DELAY = 8
) (
  input logic                   refclk,
  input logic                   rst,
  pll_reset_supervisor_if.slave bus
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;

  localparam int TW = 20;
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_VAL  = TW'(LOCK_TIMEOUT);
  localparam logic [TW-1:0] RELEASE_LAST = TW'(RELEASE_DELAY - 1);
  localparam logic [SW-1:0] STABLE_VAL   = SW'(LOCK_STABLE);
  localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRIES);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [7:0]    lock_loss_q, lock_loss_d;
  logic [1:0]    retry_q, retry_d;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_q, sys_rst_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic          locked_meta_q;
  logic          locked_s_q;

  logic [TW-1:0] timer_inc;
  logic [SW-1:0] stable_inc;
  logic [1:0]    retry_inc;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    stable_d    = stable_q;
    lock_loss_d = lock_loss_q;
    retry_d     = retry_q;
    timer_inc   = timer_q + 1'b1;
    stable_inc  = locked_s_q ? stable_q + 1'b1 : '0;
    retry_inc   = retry_q + 2'd1;

    if (bus.sw_reset_req) begin
      state_d  = S_RESET_PLL;
      timer_d  = '0;
      stable_d = '0;
      retry_d  = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (timer_q == RST_LAST) begin
            state_d  = S_WAIT_LOCK;
            timer_d  = '0;
            stable_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        // Lock qualification is checked before the timeout so a lock that
        // completes on the timeout cycle still counts.
        S_WAIT_LOCK: begin
          timer_d  = timer_inc;
          stable_d = stable_inc;
          if (stable_inc == STABLE_VAL) begin
            state_d = S_RELEASE;
            timer_d = '0;
          end else if (timer_inc == TIMEOUT_VAL) begin
            retry_d  = retry_inc;
            timer_d  = '0;
            stable_d = '0;
            state_d  = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
          end
        end
        S_RELEASE: begin
          if (!locked_s_q) begin
            state_d  = S_RESET_PLL;
            timer_d  = '0;
            stable_d = '0;
          end else if (timer_q == RELEASE_LAST) begin
            state_d = S_RUN;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        S_RUN: begin
          if (!locked_s_q) begin
            state_d  = S_RESET_PLL;
            timer_d  = '0;
            stable_d = '0;
            if (lock_loss_q != 8'hFF) begin
              lock_loss_d = lock_loss_q + 8'd1;
            end
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d  = S_RESET_PLL;
          timer_d  = '0;
          stable_d = '0;
        end
      endcase
    end

    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q       <= S_RESET_PLL;
      timer_q       <= '0;
      stable_q      <= '0;
      lock_loss_q   <= '0;
      retry_q       <= '0;
      pll_rst_q     <= 1'b1;
      sys_rst_q     <= 1'b1;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      stable_q      <= stable_d;
      lock_loss_q   <= lock_loss_d;
      retry_q       <= retry_d;
      pll_rst_q     <= pll_rst_d;
      sys_rst_q     <= sys_rst_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
      locked_meta_q <= bus.pll_locked;
      locked_s_q    <= locked_meta_q;
    end
  end

  assign bus.pll_rst         = pll_rst_q;
  assign bus.sys_rst         = sys_rst_q;
  assign bus.ready           = ready_q;
  assign bus.fail            = fail_q;
  assign bus.lock_loss_count = lock_loss_q;
  assign bus.retry_count     = retry_q;

endmodule
